// File: rtl/logic_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_sequencer
// Brief    : Command FIFO and issue sequencer for the 64-bit logic unit.
//            Buffers tagged commands, issues each with a one-cycle enable,
//            captures the unit's registered result and returns it with its tag.
// Option   : LOGIC_SEQ_CHECK_EN builds a local result checker that drives
//            rsp_mismatch; otherwise rsp_mismatch is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [63:0]      cmd_opa,
    input  logic [63:0]      cmd_opb,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             lu_enable,
    output logic [2:0]       lu_operation,
    output logic [63:0]      lu_opa,
    output logic [63:0]      lu_opb,
    input  logic [63:0]      lu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             rsp_mismatch,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 64 + 64 + TAG_W;
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [2:0]  OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [EW-1:0]    head;
    logic [2:0]       head_op;
    logic [63:0]      head_opa, head_opb;
    logic [TAG_W-1:0] head_tag;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = cmd_valid && !full;
    assign pop   = (state == IDLE) && !empty;

    assign head = mem[rd_ptr[AW-1:0]];
    assign {head_op, head_opa, head_opb, head_tag} = head;

    assign cmd_ready = !full;
    assign lu_enable = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = !empty || (state != IDLE);

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_opa, cmd_opb, cmd_tag};
        end
    end

    // FIFO pointers; a reset empties the queue and discards its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: one command in flight, illegal opcodes skip the unit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = (head_op == OP_ILLEGAL) ? RESP : ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue registers drive the unit directly; only legal commands load them
    // so the buses keep the last value actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_operation <= '0;
            lu_opa       <= '0;
            lu_opb       <= '0;
        end else if (pop && head_op != OP_ILLEGAL) begin
            lu_operation <= head_op;
            lu_opa       <= head_opa;
            lu_opb       <= head_opb;
        end
    end

    // Response registers change only at pop and capture, never during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else if (pop) begin
            rsp_tag <= head_tag;
            if (head_op == OP_ILLEGAL) begin
                rsp_err  <= 1'b1;
                rsp_data <= '0;
            end
        end else if (state == CAPTURE) begin
            rsp_data <= lu_out;
            rsp_err  <= 1'b0;
        end
    end

`ifdef LOGIC_SEQ_CHECK_EN
    // Reference result for the command currently held in the issue registers.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
        case (op)
            3'b000:  ref_result = a & b;
            3'b001:  ref_result = ~(a & b);
            3'b010:  ref_result = a | b;
            3'b011:  ref_result = ~(a | b);
            3'b100:  ref_result = a ^ b;
            3'b101:  ref_result = ~(a ^ b);
            3'b110:  ref_result = ~a;
            default: ref_result = '0;
        endcase
    endfunction

    logic mismatch_q;

    // Flag a unit result that disagrees with the local reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (pop) begin
            mismatch_q <= 1'b0;
        end else if (state == CAPTURE) begin
            mismatch_q <= (lu_out != ref_result(lu_operation, lu_opa, lu_opb));
        end
    end

    assign rsp_mismatch = mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_sequencer
// Brief    : Self-checking bench for logic_op_sequencer with a behavioural
//            logic-unit model and an in-order response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_op_sequencer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef LOGIC_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [63:0] A = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] B = 64'h0F0F0F0F0F0F0F0F;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [63:0]      cmd_opa = '0, cmd_opb = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             lu_enable;
    logic [2:0]       lu_operation;
    logic [63:0]      lu_opa, lu_opb;
    logic [63:0]      lu_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err, rsp_mismatch, busy;

    logic corrupt = 1'b0;

    int checks = 0;
    int errors = 0;
    int lu_count = 0;

    typedef struct {
        logic [2:0]       op;
        logic [63:0]      a, b, data;
        logic [TAG_W-1:0] tag;
        logic             err, mm;
    } exp_t;

    exp_t        q[$];
    logic [63:0] rx_data[$];
    logic [7:0]  rx_tag[$];
    logic        rx_err[$];
    logic        rx_mm[$];

    always #5 clk = ~clk;

    logic_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_tag(cmd_tag),
        .lu_enable(lu_enable), .lu_operation(lu_operation),
        .lu_opa(lu_opa), .lu_opb(lu_opb), .lu_out(lu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch),
        .busy(busy)
    );

    function automatic logic [63:0] lu_fn(input logic [2:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return ~(a & b);
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Logic unit model: result registered one cycle after enable.
    always @(posedge clk or posedge rst) begin
        if (rst)            lu_out <= '0;
        else if (lu_enable) lu_out <= lu_fn(lu_operation, lu_opa, lu_opb) ^ {63'd0, corrupt};
    end

    // Scoreboard fill: every accepted command owes exactly one response.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (cmd_valid && cmd_ready) begin
            exp_t e;
            e.op  = cmd_op;
            e.a   = cmd_opa;
            e.b   = cmd_opb;
            e.tag = cmd_tag;
            e.err = (cmd_op == 3'd7);
            e.data = e.err ? 64'd0 : (lu_fn(cmd_op, cmd_opa, cmd_opb) ^ {63'd0, corrupt});
            e.mm  = e.err ? 1'b0 : (CHK & corrupt);
            q.push_back(e);
        end
    end

    // Per-cycle comparison against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", {63'd0, busy}, {63'd0, q.size() != 0});
            if (lu_enable) begin
                lu_count++;
                if (q.size() == 0) begin
                    check("lu_enable_unexpected", 64'd1, 64'd0);
                end else begin
                    check("lu_enable_on_illegal", {63'd0, q[0].err}, 64'd0);
                    check("lu_operation", {61'd0, lu_operation}, {61'd0, q[0].op});
                    check("lu_opa", lu_opa, q[0].a);
                    check("lu_opb", lu_opb, q[0].b);
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    check("rsp_data", rsp_data, q[0].data);
                    check("rsp_tag", {{(64-TAG_W){1'b0}}, rsp_tag}, {{(64-TAG_W){1'b0}}, q[0].tag});
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, q[0].err});
                    check("rsp_mismatch", {63'd0, rsp_mismatch}, {63'd0, q[0].mm});
                    if (rsp_ready) begin
                        rx_data.push_back(rsp_data);
                        rx_tag.push_back(8'(rsp_tag));
                        rx_err.push_back(rsp_err);
                        rx_mm.push_back(rsp_mismatch);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [TAG_W-1:0] tag);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_opa = a;
        cmd_opb = b;
        cmd_tag = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 64'd1, 64'd0);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int en0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset_lu_enable", {63'd0, lu_enable}, 64'd0);
        check("reset_lu_operation", {61'd0, lu_operation}, 64'd0);
        check("reset_lu_opa", lu_opa, 64'd0);
        check("reset_lu_opb", lu_opb, 64'd0);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("reset_rsp_mismatch", {63'd0, rsp_mismatch}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // Single AND command with latency checks
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push_cmd(3'd0, A, B, 4'd3);
        @(negedge clk);
        check("t1_lu_enable", {63'd0, lu_enable}, 64'd0);
        @(negedge clk);
        check("t2_lu_enable", {63'd0, lu_enable}, 64'd1);
        @(negedge clk);
        check("t3_lu_enable", {63'd0, lu_enable}, 64'd0);
        check("t3_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t4_rsp_data", rsp_data, 64'h0F0F00000F0F0000);
        check("t4_rsp_tag", {60'd0, rsp_tag}, 64'd3);
        check("t4_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("t4_rsp_mismatch", {63'd0, rsp_mismatch}, 64'd0);
        wait_idle();

        // Back-to-back XOR, NOT, illegal
        base = rx_data.size();
        en0 = lu_count;
        @(posedge clk); #1;
        push_cmd(3'd4, A, B, 4'd1);
        push_cmd(3'd6, A, B, 4'd2);
        push_cmd(3'd7, A, B, 4'd3);
        wait_idle();
        check("b2b_enable_count", 64'(lu_count - en0), 64'd2);
        check("b2b_rsp_count", 64'(rx_data.size() - base), 64'd3);
        if (rx_data.size() >= base + 3) begin
            check("b2b_xor_data", rx_data[base], 64'hF0F00F0FF0F00F0F);
            check("b2b_xor_tag", 64'(rx_tag[base]), 64'd1);
            check("b2b_not_data", rx_data[base+1], 64'h0000FFFF0000FFFF);
            check("b2b_not_tag", 64'(rx_tag[base+1]), 64'd2);
            check("b2b_ill_data", rx_data[base+2], 64'd0);
            check("b2b_ill_err", 64'(rx_err[base+2]), 64'd1);
            check("b2b_ill_tag", 64'(rx_tag[base+2]), 64'd3);
        end

        // Fill with rsp_ready low, then drain
        base = rx_data.size();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_cmd(3'(i % 6), A ^ 64'(i), B, TAG_W'(i + 4));
        end
        @(negedge clk);
        check("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        repeat (4) @(negedge clk);
        check("full_cmd_ready_held", {63'd0, cmd_ready}, 64'd0);
        check("full_rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();
        check("drain_rsp_count", 64'(rx_data.size() - base), 64'(DEPTH + 1));
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (base + i < rx_tag.size())
                check("drain_tag_order", 64'(rx_tag[base+i]), 64'(i + 4));
        end

        // Corrupted unit result on AND
        @(posedge clk); #1;
        corrupt = 1'b1;
        push_cmd(3'd0, A, B, 4'd5);
        wait_idle();
        corrupt = 1'b0;
        if (rx_data.size() > 0) begin
            check("corrupt_data", rx_data[rx_data.size()-1], 64'h0F0F00000F0F0001);
            check("corrupt_mismatch", 64'(rx_mm[rx_mm.size()-1]), 64'(CHK));
        end

        // Reset during CAPTURE with two commands queued
        @(posedge clk); #1;
        push_cmd(3'd2, A, B, 4'd7);
        push_cmd(3'd2, A, B, 4'd8);
        push_cmd(3'd2, A, B, 4'd9);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        base = rx_data.size();
        en0 = lu_count;
        repeat (20) @(negedge clk);
        check("rst_no_response", 64'(rx_data.size() - base), 64'd0);
        check("rst_no_enable", 64'(lu_count - en0), 64'd0);
        check("rst_idle_busy", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
